// File: rtl/bus_interconnect_if.sv
// Bus bundle for the single-master / two-slave interconnect.
// The master, slave and fabric modports give each party its own direction view.
interface bus_interconnect_if #(
    parameter int AW = 16,
    parameter int DW = 64
);
    logic          m_req;
    logic          m_wr;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_dout;
    logic          m_grant;
    logic [DW-1:0] m_din;
    logic          s0_sel;
    logic          s1_sel;
    logic [AW-1:0] s_addr;
    logic [DW-1:0] s_din;
    logic          s_wr;
    logic [DW-1:0] s0_dout;
    logic [DW-1:0] s1_dout;

    modport master (
        output m_req, m_wr, m_addr, m_dout,
        input  m_grant, m_din
    );

    modport slave (
        input  s0_sel, s1_sel, s_addr, s_din, s_wr,
        output s0_dout, s1_dout
    );

    modport fabric (
        input  m_req, m_wr, m_addr, m_dout, s0_dout, s1_dout,
        output m_grant, m_din, s0_sel, s1_sel, s_addr, s_din, s_wr
    );
endinterface

// File: rtl/bus_interconnect.sv
// Single-master, two-slave interconnect: grant FSM, address decoder and
// one-cycle-delayed read-data return mux.
module bus_interconnect #(
    parameter int            AW      = 16,
    parameter int            DW      = 64,
    parameter logic [15:0]   S0_BASE = 16'h0000,
    parameter logic [15:0]   S1_BASE = 16'h0800
) (
    input  logic              clk,
    input  logic              reset_n,
    bus_interconnect_if.fabric bus
);
    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_GRANT = 1'b1;
    localparam int         WIN_LSB  = 11;

    logic [0:0]    state_q;
    logic [0:0]    state_d;
    logic [1:0]    rsel_q;
    logic [1:0]    rsel_d;
    logic          grant_s;
    logic [AW-1:0] s_addr_s;
    logic [DW-1:0] s_din_s;
    logic          s_wr_s;
    logic [1:0]    sel_s;
    logic [DW-1:0] m_din_s;

    // Window match on the top address bits; returns {s1_hit, s0_hit}.
    function automatic logic [1:0] decode_win(input logic [AW-1:0] addr);
        logic [1:0] hit;
        hit    = 2'b00;
        hit[0] = (addr[AW-1:WIN_LSB] == S0_BASE[AW-1:WIN_LSB]);
        hit[1] = (addr[AW-1:WIN_LSB] == S1_BASE[AW-1:WIN_LSB]);
        return hit;
    endfunction

    // Arbiter next state: hold the grant for as long as the master requests.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.m_req) begin
                    state_d = ST_GRANT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_GRANT: begin
                if (bus.m_req) begin
                    state_d = ST_GRANT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign grant_s = (state_q == ST_GRANT);

    // Forward master signals only while granted; otherwise park the slave bus at zero.
    always_comb begin
        s_addr_s = {AW{1'b0}};
        s_din_s  = {DW{1'b0}};
        s_wr_s   = 1'b0;
        sel_s    = 2'b00;
        if (grant_s) begin
            s_addr_s = bus.m_addr;
            s_din_s  = bus.m_dout;
            s_wr_s   = bus.m_wr;
            sel_s    = decode_win(bus.m_addr);
        end else begin
            s_addr_s = {AW{1'b0}};
            s_din_s  = {DW{1'b0}};
            s_wr_s   = 1'b0;
            sel_s    = 2'b00;
        end
    end

    assign rsel_d = sel_s;

    // Read return is a live mux keyed on last cycle's select, not a data latch.
    always_comb begin
        m_din_s = {DW{1'b0}};
        case (rsel_q)
            2'b01:   m_din_s = bus.s0_dout;
            2'b10:   m_din_s = bus.s1_dout;
            default: m_din_s = {DW{1'b0}};
        endcase
    end

    // Arbiter state and captured read select.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            rsel_q  <= 2'b00;
        end else begin
            state_q <= state_d;
            rsel_q  <= rsel_d;
        end
    end

    assign bus.m_grant = grant_s;
    assign bus.s_addr  = s_addr_s;
    assign bus.s_din   = s_din_s;
    assign bus.s_wr    = s_wr_s;
    assign bus.s0_sel  = sel_s[0];
    assign bus.s1_sel  = sel_s[1];
    assign bus.m_din   = m_din_s;
endmodule

// File: tb/tb_bus_interconnect.sv
// Directed self-checking bench for bus_interconnect.
module tb_bus_interconnect;
    logic clk;
    logic reset_n;
    int   total;
    int   bad;

    localparam logic [63:0] S0_VAL  = 64'hABCDABCD_ABCDABCD;
    localparam logic [63:0] S1_VAL  = 64'h12341234_12341234;
    localparam logic [63:0] WR_VAL  = 64'h2_2256_AAAA;
    localparam logic [63:0] S1_ALT  = 64'hDEADBEEF_00C0FFEE;

    bus_interconnect_if #(.AW(16), .DW(64)) bus ();

    bus_interconnect dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        bus.m_req = 1'b0; bus.m_wr = 1'b0; bus.m_addr = 16'hF0F0; bus.m_dout = 64'h0;
        bus.s0_dout = S0_VAL; bus.s1_dout = S1_VAL;
        #3;
        tick(); tick();
        total++; if (bus.m_grant !== 1'b0) begin bad++; $display("FAIL reset_grant got=%h exp=0", bus.m_grant); end
        total++; if (bus.s_addr !== 16'h0) begin bad++; $display("FAIL reset_s_addr got=%h exp=0", bus.s_addr); end
        total++; if (bus.s_din !== 64'h0 || bus.s_wr !== 1'b0) begin bad++; $display("FAIL reset_s_din_wr got=%h/%h exp=0/0", bus.s_din, bus.s_wr); end
        total++; if ({bus.s1_sel, bus.s0_sel} !== 2'b00) begin bad++; $display("FAIL reset_sel got=%b exp=00", {bus.s1_sel, bus.s0_sel}); end
        total++; if (bus.m_din !== 64'h0) begin bad++; $display("FAIL reset_m_din got=%h exp=0", bus.m_din); end
        reset_n = 1'b1;
        tick();
        total++; if (bus.m_grant !== 1'b0) begin bad++; $display("FAIL idle_grant got=%h exp=0", bus.m_grant); end
    endtask

    task automatic test_grant();
        bus.m_req = 1'b1; bus.m_addr = 16'h70CC; bus.m_wr = 1'b0;
        #1;
        total++; if (bus.m_grant !== 1'b0) begin bad++; $display("FAIL grant_early got=%h exp=0", bus.m_grant); end
        tick();
        total++; if (bus.m_grant !== 1'b1) begin bad++; $display("FAIL grant_rise got=%h exp=1", bus.m_grant); end
        total++; if (bus.s_addr !== 16'h70CC) begin bad++; $display("FAIL grant_s_addr got=%h exp=70cc", bus.s_addr); end
        total++; if ({bus.s1_sel, bus.s0_sel} !== 2'b00) begin bad++; $display("FAIL grant_nosel got=%b exp=00", {bus.s1_sel, bus.s0_sel}); end
        tick();
        total++; if (bus.m_din !== 64'h0) begin bad++; $display("FAIL grant_m_din got=%h exp=0", bus.m_din); end
    endtask

    task automatic test_write_s0();
        bus.m_addr = 16'h00AA; bus.m_wr = 1'b1; bus.m_dout = WR_VAL;
        #1;
        total++; if (bus.s0_sel !== 1'b1 || bus.s1_sel !== 1'b0) begin bad++; $display("FAIL wr_sel got=%b%b exp=01", bus.s1_sel, bus.s0_sel); end
        total++; if (bus.s_wr !== 1'b1) begin bad++; $display("FAIL wr_s_wr got=%h exp=1", bus.s_wr); end
        total++; if (bus.s_din !== WR_VAL) begin bad++; $display("FAIL wr_s_din got=%h exp=%h", bus.s_din, WR_VAL); end
        tick();
        total++; if (bus.m_din !== S0_VAL) begin bad++; $display("FAIL wr_m_din got=%h exp=%h", bus.m_din, S0_VAL); end
    endtask

    task automatic test_read_boundary();
        logic [15:0] addrs [4];
        logic [1:0]  sels  [4];
        logic [63:0] dins  [4];
        addrs = '{16'h07FF, 16'h0800, 16'h0FFF, 16'h1000};
        sels  = '{2'b01, 2'b10, 2'b10, 2'b00};
        dins  = '{S0_VAL, S1_VAL, S1_VAL, 64'h0};
        bus.m_wr = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bus.m_addr = addrs[i];
            #1;
            total++; if ({bus.s1_sel, bus.s0_sel} !== sels[i]) begin bad++; $display("FAIL rd_sel[%0h] got=%b exp=%b", addrs[i], {bus.s1_sel, bus.s0_sel}, sels[i]); end
            tick();
            total++; if (bus.m_din !== dins[i]) begin bad++; $display("FAIL rd_m_din[%0h] got=%h exp=%h", addrs[i], bus.m_din, dins[i]); end
        end
    endtask

    task automatic test_live_mux();
        bus.m_addr = 16'h0900; bus.m_wr = 1'b0;
        tick();
        total++; if (bus.m_din !== S1_VAL) begin bad++; $display("FAIL live_m_din got=%h exp=%h", bus.m_din, S1_VAL); end
        bus.s1_dout = S1_ALT;
        #1;
        total++; if (bus.m_din !== S1_ALT) begin bad++; $display("FAIL live_track got=%h exp=%h", bus.m_din, S1_ALT); end
        bus.s1_dout = S1_VAL;
    endtask

    task automatic test_release();
        bus.m_addr = 16'h07FF; bus.m_wr = 1'b1; bus.m_req = 1'b0;
        #1;
        total++; if (bus.m_grant !== 1'b1 || bus.s0_sel !== 1'b1) begin bad++; $display("FAIL rel_hold got=%h/%h exp=1/1", bus.m_grant, bus.s0_sel); end
        tick();
        total++; if (bus.m_grant !== 1'b0) begin bad++; $display("FAIL rel_grant got=%h exp=0", bus.m_grant); end
        total++; if (bus.s_wr !== 1'b0 || bus.s_addr !== 16'h0 || bus.s_din !== 64'h0) begin bad++; $display("FAIL rel_fwd got=%h/%h/%h exp=0/0/0", bus.s_wr, bus.s_addr, bus.s_din); end
        total++; if ({bus.s1_sel, bus.s0_sel} !== 2'b00) begin bad++; $display("FAIL rel_sel got=%b exp=00", {bus.s1_sel, bus.s0_sel}); end
        total++; if (bus.m_din !== S0_VAL) begin bad++; $display("FAIL rel_m_din_hold got=%h exp=%h", bus.m_din, S0_VAL); end
        bus.m_addr = 16'h0800;
        #1;
        total++; if ({bus.s1_sel, bus.s0_sel} !== 2'b00) begin bad++; $display("FAIL rel_sel_s1 got=%b exp=00", {bus.s1_sel, bus.s0_sel}); end
        tick();
        total++; if (bus.m_din !== 64'h0) begin bad++; $display("FAIL rel_m_din got=%h exp=0", bus.m_din); end
    endtask

    task automatic test_async_reset();
        bus.m_req = 1'b1; bus.m_addr = 16'h0800; bus.m_wr = 1'b0;
        tick();
        total++; if (bus.m_grant !== 1'b1 || bus.s1_sel !== 1'b1) begin bad++; $display("FAIL ar_pre got=%h/%h exp=1/1", bus.m_grant, bus.s1_sel); end
        tick();
        total++; if (bus.m_din !== S1_VAL) begin bad++; $display("FAIL ar_pre_din got=%h exp=%h", bus.m_din, S1_VAL); end
        #1;
        reset_n = 1'b0;
        #1;
        total++; if (bus.m_grant !== 1'b0 || bus.s1_sel !== 1'b0 || bus.s_addr !== 16'h0) begin bad++; $display("FAIL ar_now got=%h/%h/%h exp=0/0/0", bus.m_grant, bus.s1_sel, bus.s_addr); end
        total++; if (bus.m_din !== 64'h0) begin bad++; $display("FAIL ar_m_din got=%h exp=0", bus.m_din); end
        reset_n = 1'b1;
        #1;
        total++; if (bus.m_grant !== 1'b0) begin bad++; $display("FAIL ar_released got=%h exp=0", bus.m_grant); end
        tick();
        total++; if (bus.m_grant !== 1'b1 || bus.s1_sel !== 1'b1) begin bad++; $display("FAIL ar_regrant got=%h/%h exp=1/1", bus.m_grant, bus.s1_sel); end
        total++; if (bus.m_din !== 64'h0) begin bad++; $display("FAIL ar_regrant_din got=%h exp=0", bus.m_din); end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_grant();
        test_write_s0();
        test_read_boundary();
        test_live_mux();
        test_release();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
